// File: rtl/seg7_pkg.sv
// Shared constants and the nibble-to-segment decode for the seven-segment scanner.
// Contents: SEG_BLANK (all segments off), SEG_TABLE (hex glyphs, active-low {g..a}),
//           hex2seg() lookup used by seg7_hexdec.
package seg7_pkg;

    // All segments off; a blanked leading-zero digit drives this.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs. Index 15 ('F') is listed first
    // because a packed concatenation fills from the MSB down.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bundle between the CPU-side producer and the seven-segment scanner.
// master: drives value/blank_lz/dp_in, observes the panel outputs.
// slave:  the scanner; consumes the display word and drives an/seg/dp/frame_tick.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output value, blank_lz, dp_in,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  value, blank_lz, dp_in,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg7_hexdec.sv
// Purpose: single hex nibble to active-low seven-segment glyph.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
// Ports: nib_i (4b hex digit) -> seg_o (7b active-low {g..a}).
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan.sv
// Purpose: time-multiplexed 8-digit hex display driver with per-frame snapshot of the display word.
// Latency: an/seg/dp registered, updated on the same edge the digit index advances; new word visible at digit 0 of the next frame.
// Backpressure: none; free-running, never stalls the producer.
// Ports: clk, rst_n (async active-low), bus (slave: value/blank_lz/dp_in in, an/seg/dp/frame_tick out).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    // A 1-bit prescaler is kept for SCAN_DIV==1 so the counter never collapses to zero width.
    localparam int                PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]     PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam int                IW       = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]     IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam int                VW       = 4 * NUM_DIGITS;

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  ft_q, ft_d;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic [6:0]            hex_seg;
    logic                  upper_zero;
    logic                  lz_blank;

    seg7_hexdec u_hexdec (
        .nib_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        tick       = (pre_q == PRE_MAX);
        wrap       = tick && (idx_q == IDX_LAST);

        pre_d      = tick ? '0 : pre_q + 1'b1;
        idx_d      = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Capture only at the frame boundary so a frame is never torn.
        snap_val_d = wrap ? bus.value : snap_val_q;
        snap_dp_d  = wrap ? bus.dp_in : snap_dp_q;

        // Walk from the top digit down, tracking whether every nibble at or
        // above the current position is zero; record that for the digit about
        // to be shown. Digit 0 is never eligible for blanking.
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        nib        = 4'h0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (snap_val_d[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
            if (IW'(i) == idx_d) begin
                nib      = snap_val_d[4*i +: 4];
                lz_blank = (i != 0) && upper_zero;
            end
        end

        // Outputs are computed from the post-edge index and snapshot, so the
        // wrap edge already presents digit 0 of the newly captured word.
        an_d = ~(NUM_DIGITS'(1) << idx_d);
        seg_d = (bus.blank_lz && lz_blank) ? SEG_BLANK : hex_seg;
        dp_d  = ~snap_dp_d[idx_d];
        ft_d  = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            seg_q      <= SEG_TABLE[0];
            dp_q       <= 1'b1;
            ft_q       <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            ft_q       <= ft_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = ft_q;

endmodule
